// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, LSU FSM state type and byte-lane helpers
// shared by the memory stage and its alignment datapath.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_RSP
  } lsu_state_e;

  // A doubleword request on a 32-bit datapath degrades to a word access.
  function automatic logic [1:0] size_clamp(input logic [1:0] size, input logic rv64);
    return (!rv64 && size == SZ_D) ? SZ_W : size;
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Contiguous byte enables of the given length starting at lane ofs.
  function automatic logic [7:0] wmask_gen(input logic [3:0] bytes, input logic [2:0] ofs);
    return 8'((16'd1 << bytes) - 16'd1) << ofs;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane alignment of store data and extraction plus
// sign/zero extension of load data from a full-width memory word.
module mem_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NB    = XLEN / 8,
  parameter int unsigned OFS_W = $clog2(NB)
) (
  input  logic [1:0]       st_size,
  input  logic [OFS_W-1:0] st_ofs,
  input  logic [XLEN-1:0]  st_data,
  output logic [NB-1:0]    wmask,
  output logic [XLEN-1:0]  wdata,
  input  logic [1:0]       ld_size,
  input  logic             ld_zext,
  input  logic [OFS_W-1:0] ld_ofs,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  ld_data
);

  logic [3:0]      st_bytes;
  logic [3:0]      ld_bytes;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  // Store path: byte enables and lane-shifted data.
  always_comb begin
    st_bytes = size_bytes(st_size);
    wmask    = NB'(wmask_gen(st_bytes, 3'(st_ofs)));
    wdata    = st_data << {st_ofs, 3'b000};
  end

  // Load path: shift the addressed bytes down, keep the access width, extend the rest.
  always_comb begin
    ld_bytes = size_bytes(ld_size);
    shifted  = rdata >> {ld_ofs, 3'b000};
    // Shifting by the full width yields zero, so a full-width access keeps every bit.
    keep     = ~({XLEN{1'b1}} << {ld_bytes, 3'b000});
    unique case (ld_size)
      SZ_B:    sign = shifted[7];
      SZ_H:    sign = shifted[15];
      SZ_W:    sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    ld_data = shifted & keep;
    if (sign && !ld_zext) begin
      ld_data = ld_data | ~keep;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: pipeline memory stage. Issues one valid/ready data-memory request
// at a time, stalls M while the request or load response is pending, and registers
// results into writeback. Build option MEM_MISALIGN_TRAP_EN flags misaligned accesses
// instead of aligning them down.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_valid,
  input  logic                 m_reg_write,
  input  logic                 m_mem_read,
  input  logic                 m_mem_write,
  input  logic [2:0]           m_funct3,
  input  logic [XLEN-1:0]      m_alu_out,
  input  logic [XLEN-1:0]      m_store_data,
  input  logic [4:0]           m_rd,
  output logic                 stall_m,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_we,
  output logic [ADDR_W-1:0]    dmem_req_addr,
  output logic [XLEN/8-1:0]    dmem_req_wmask,
  output logic [XLEN-1:0]      dmem_req_wdata,
  input  logic                 dmem_rsp_valid,
  input  logic [XLEN-1:0]      dmem_rsp_rdata,
  output logic                 w_valid,
  output logic                 w_reg_write,
  output logic                 w_mem_to_reg,
  output logic [4:0]           w_rd,
  output logic [XLEN-1:0]      w_alu_out,
  output logic [XLEN-1:0]      w_read_data,
  output logic                 w_misalign
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFS_W = $clog2(NB);

  lsu_state_e       state_q, state_d;
  logic [1:0]       lat_size_q, lat_size_d;
  logic             lat_zext_q, lat_zext_d;
  logic [OFS_W-1:0] lat_ofs_q, lat_ofs_d;

  logic [1:0]       size;
  logic [3:0]       bytes;
  logic [OFS_W-1:0] ofs;
  logic [OFS_W-1:0] ofs_eff;
  logic             is_mem;
  logic             misaligned;
  logic             mem_op;
  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  wb_read_data;

  assign size   = size_clamp(m_funct3[1:0], XLEN == 64);
  assign bytes  = size_bytes(size);
  assign ofs    = m_alu_out[OFS_W-1:0];
  assign is_mem = m_valid & (m_mem_read | m_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_mem & ((4'(ofs) & (bytes - 4'd1)) != 4'd0);
  assign ofs_eff    = ofs;
`else
  // Low log2(bytes) offset bits are ignored: the access is aligned down.
  assign misaligned = 1'b0;
  assign ofs_eff    = OFS_W'(4'(ofs) & ~(bytes - 4'd1));
`endif

  assign mem_op = is_mem & ~misaligned;

  // Request fields come straight from M; stall_m keeps them stable until accepted.
  assign dmem_req_we   = m_mem_write & ~m_mem_read;
  assign dmem_req_addr = {m_alu_out[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  mem_align #(
    .XLEN (XLEN),
    .NB   (NB),
    .OFS_W(OFS_W)
  ) u_align (
    .st_size(size),
    .st_ofs (ofs_eff),
    .st_data(m_store_data),
    .wmask  (dmem_req_wmask),
    .wdata  (dmem_req_wdata),
    .ld_size(lat_size_q),
    .ld_zext(lat_zext_q),
    .ld_ofs (lat_ofs_q),
    .rdata  (dmem_rsp_rdata),
    .ld_data(ld_data)
  );

  // Next-state, request handshake and stall generation.
  always_comb begin
    state_d        = state_q;
    lat_size_d     = lat_size_q;
    lat_zext_d     = lat_zext_q;
    lat_ofs_d      = lat_ofs_q;
    dmem_req_valid = 1'b0;
    stall_m        = 1'b0;
    // Outputs stay quiet while reset is asserted even if M presents an op.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          dmem_req_valid = mem_op;
          if (mem_op) begin
            // Accepted stores are posted; everything else holds M.
            stall_m = ~(dmem_req_ready & dmem_req_we);
            if (dmem_req_ready && !dmem_req_we) begin
              state_d    = WAIT_RSP;
              lat_size_d = size;
              lat_zext_d = m_funct3[2];
              lat_ofs_d  = ofs_eff;
            end
          end
        end
        WAIT_RSP: begin
          stall_m = ~dmem_rsp_valid;
          if (dmem_rsp_valid) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Only a completing load carries memory data into writeback.
  assign wb_read_data = (state_q == WAIT_RSP) ? ld_data : '0;

  // FSM state and latched load attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_size_q <= SZ_B;
      lat_zext_q <= 1'b0;
      lat_ofs_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_size_q <= lat_size_d;
      lat_zext_q <= lat_zext_d;
      lat_ofs_q  <= lat_ofs_d;
    end
  end

  // Writeback register: capture M when advancing, otherwise insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid      <= 1'b0;
      w_reg_write  <= 1'b0;
      w_mem_to_reg <= 1'b0;
      w_rd         <= '0;
      w_alu_out    <= '0;
      w_read_data  <= '0;
      w_misalign   <= 1'b0;
    end else if (stall_m) begin
      w_valid     <= 1'b0;
      w_reg_write <= 1'b0;
    end else begin
      w_valid      <= m_valid;
      w_reg_write  <= m_valid & m_reg_write & ~misaligned;
      w_mem_to_reg <= m_mem_read;
      w_rd         <= m_rd;
      w_alu_out    <= m_alu_out;
      w_read_data  <= wb_read_data;
      w_misalign   <= misaligned;
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor of the pipeline memory stage. Handles RV32/RV64 loads and stores (B/H/W/D) over a valid/ready data-memory request port with variable response latency.
- Generates byte-lane write masks and store data, and extracts and extends load data.
- Stalls the upstream pipeline while memory is busy.
- Registers results into the writeback stage.
- Sits between the execute/M pipeline register and the writeback stage.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- ADDR_W, 32, data-memory address width.
- NB (localparam), XLEN/8, number of byte lanes.
- OFS_W (localparam), log2(NB), width of the byte offset within a word.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_valid  in  1  a valid instruction is present in M.
- m_reg_write  in  1  instruction writes rd.
- m_mem_read  in  1  load; selects memory data at writeback.
- m_mem_write  in  1  store.
- m_funct3  in  3  [1:0] size: 00=B, 01=H, 10=W, 11=D. [2]=1 zero-extend on load.
- m_alu_out  in  XLEN  effective address, or ALU result.
- m_store_data  in  XLEN  rs2 value.
- m_rd  in  5  destination register.
- stall_m  out  1  upstream must hold all m_* inputs this cycle.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1=store, 0=load.
- dmem_req_addr  out  ADDR_W  address with the low OFS_W bits cleared.
- dmem_req_wmask  out  NB  byte-enable mask.
- dmem_req_wdata  out  XLEN  lane-aligned store data.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rsp_rdata  in  XLEN  full-word load data.
- w_valid  out  1  WB holds a valid instruction.
- w_reg_write  out  1  WB writes rd.
- w_mem_to_reg  out  1  WB selects w_read_data.
- w_rd  out  5  WB destination register.
- w_alu_out  out  XLEN  registered ALU result.
- w_read_data  out  XLEN  registered, extended load data.
- w_misalign  out  1  misaligned-access flag.

Behaviour:
- Reset: clk plus asynchronous active-low rst_n.
  - While rst_n is low: FSM=IDLE, and every w_* output is 0.
  - dmem_req_valid=0 and stall_m=0.
- Size handling:
  - bytes = 1<<size. With XLEN=32, size 11 is treated as W.
  - ofs = m_alu_out[OFS_W-1:0].
  - wmask = ((1<<bytes)-1) << ofs.
  - wdata = m_store_data << (8*ofs).
- Load extraction:
  - The result is (rsp_rdata >> 8*ofs) truncated to the access size.
  - It is sign-extended when funct3[2]=0 and zero-extended when funct3[2]=1.
- mem_op = m_valid & (m_mem_read | m_mem_write) & ~misaligned. This is the aligned case; see Optional Feature for misaligned handling.
- FSM, state IDLE:
  - dmem_req_valid = mem_op. The request fields are combinational from the m_* inputs, which stay stable because stall_m holds them.
  - Store accepted (req_valid & ready): the store is posted, stall_m=0, and the instruction advances this cycle.
  - Load accepted: latch ofs and funct3, go to WAIT_RSP, stall_m=1.
  - Not accepted: stay in IDLE, stall_m=1, request held.
  - Non-memory instruction: no request, stall_m=0.
- FSM, state WAIT_RSP:
  - dmem_req_valid=0 and stall_m = ~dmem_rsp_valid.
  - On rsp_valid: extract data using the latched ofs/funct3, then go to IDLE.
- Response timing: the earliest response is the cycle after acceptance. Minimum latency is 1 cycle for a store and 2 cycles for a load, from M entry to the WB register.
- WB register:
  - When stall_m=0, it captures the M fields plus the extracted load data (0 for non-loads).
  - When stall_m=1, it loads a bubble: w_valid=0, w_reg_write=0, all other fields held.
- dmem_rsp_valid received in IDLE is ignored. This covers a stray response after reset.
- Reset mid-operation:
  - An outstanding load is abandoned and the FSM returns to IDLE.
  - No request is reissued until new M inputs arrive after reset.
- Only one request is outstanding at a time. A new request is not issued while in WAIT_RSP.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means ofs is not a multiple of bytes.
  - A misaligned memory op issues no request and causes no stall.
  - WB captures w_valid=1, w_misalign=1, w_reg_write=0.
- Undefined:
  - The address is aligned down to the access size (low log2(bytes) bits treated as 0) and the access proceeds.
  - w_misalign is tied to 0.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - the FSM state enum (IDLE, WAIT_RSP);
  - helper functions size_bytes() and wmask_gen().
- One combinational sub-module, mem_align, holds the store lane alignment and the load extraction/extension. The FSM, stall logic and WB register stay in mem_stage_lsu.

Test Plan:
1. XLEN=32. SB of data 0x000000AB to addr 0x1003, ready=1 → wmask=1000, wdata=0xAB000000, req_addr=0x1000, stall_m=0, and the next cycle w_valid=1.
2. LH addr 0x2002 with rdata 0x8001_1234, rsp 3 cycles after acceptance → stall_m high for 3 cycles, then w_read_data=0xFFFF8001, w_mem_to_reg=1. LHU of the same access → 0x00008001.
3. Store with req_ready low for 4 cycles → req_valid held with stable addr/wmask/wdata, stall_m=1, and 4 bubbles with w_valid=0 and w_reg_write=0.
4. XLEN=64. LW addr 0x...04 with rdata 0xFFFF_FFFF_8000_0000 → w_read_data=0xFFFFFFFFFFFFFFFF. SD → wmask=0xFF.
5. rst_n asserted low in WAIT_RSP, released, then rsp_valid=1 → response ignored, no WB write, FSM in IDLE.
6. MEM_MISALIGN_TRAP_EN defined, LW to addr 0x1002 → no dmem_req_valid, w_misalign=1, w_reg_write=0. Undefined → request to 0x1000, w_misalign=0.
